// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// pipeline_stall_ctrl : zero-latency stall/flush control for a 5-stage pipeline
// Optional macro PIPE_STALL_PERF_EN builds the stall-cycle counter.  Rev 1.0
// ============================================================================
module pipeline_stall_ctrl #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_use,
  input  logic        branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  input  logic        mdu_busy,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        id_ex_we,
  output logic        ex_mem_we,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_wb_flush,
  output logic        wait_timeout,
  output logic [31:0] stall_cycles
);

  localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MDU_WAIT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;
  logic       mem_stall, mdu_stall, redirect, bubble, timeout_hit;
  logic [3:0] we;
  logic [2:0] flush;

  // MDU_WAIT re-runs the RUN priority decode every cycle, so a memory stall
  // still dominates and the first idle cycle behaves exactly like RUN.
  always_comb begin
    mem_stall = 1'b0;
    mdu_stall = 1'b0;
    redirect  = 1'b0;
    bubble    = 1'b0;
    case (state_q)
      ST_MEM_WAIT: mem_stall = !dmem_ready;
      default: begin
        mem_stall = dmem_req && !dmem_ready;
        mdu_stall = !mem_stall && mdu_busy;
        redirect  = branch_taken;
        bubble    = load_use && !branch_taken;
      end
    endcase
  end

  always_comb begin
    we    = 4'b1111;
    flush = 3'b000;
    if (!reset_n) begin
      we    = 4'b0000;
      flush = 3'b111;
    end else if (mem_stall) begin
      we    = 4'b0000;
      flush = 3'b001;
    end else if (mdu_stall) begin
      we    = 4'b0001;
    end else if (redirect) begin
      flush = 3'b110;
    end else if (bubble) begin
      we    = 4'b0011;
      flush = 3'b010;
    end
  end

  always_comb begin
    if (mem_stall)      state_d = ST_MEM_WAIT;
    else if (mdu_stall) state_d = ST_MDU_WAIT;
    else                state_d = ST_RUN;

    // The count includes the current stall cycle, restarting at 1 on entry.
    if (!(mem_stall || mdu_stall)) wait_cnt_d = 8'd0;
    else if (state_d != state_q)   wait_cnt_d = 8'd1;
    else if (wait_cnt_q != 8'hFF)  wait_cnt_d = wait_cnt_q + 8'd1;
    else                           wait_cnt_d = wait_cnt_q;

    timeout_hit = (mem_stall || mdu_stall) && (wait_cnt_d >= c_max_wait);
    timeout_d   = timeout_q || timeout_hit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign pc_we        = we[3];
  assign if_id_we     = we[2];
  assign id_ex_we     = we[1];
  assign ex_mem_we    = we[0];
  assign if_id_flush  = flush[2];
  assign id_ex_flush  = flush[1];
  assign mem_wb_flush = flush[0];
  assign wait_timeout = timeout_q || (reset_n && timeout_hit);

`ifdef PIPE_STALL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb stall_cnt_d = we[3] ? stall_cnt_q : stall_cnt_q + 32'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cnt_q <= 32'd0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule
`default_nettype wire
